// File: rtl/usb_txn_ctrl.sv
// USB host transaction sequencer: token, data/handshake phases, bounded retries and response timeout.
// Optional USB_TXN_STATS_EN adds a saturating nak_count output.
module usb_txn_ctrl #(
  parameter int MAX_RETRY = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_in,
  input  logic [6:0]  txn_addr,
  input  logic [3:0]  txn_endp,
  input  logic [63:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        success,
  output logic [63:0] rd_data,
  output logic [3:0]  pid,
  output logic [6:0]  addr,
  output logic [3:0]  endp,
  output logic [63:0] data,
  output logic        pkttype,
  output logic        pktready_bs,
  input  logic        gotpkt_bs,
  input  logic        sending_bs,
  output logic        writing,
  input  logic        in_pktready,
  input  logic [63:0] in_data,
  input  logic        in_ack,
  input  logic        in_nak,
  input  logic        in_error
`ifdef USB_TXN_STATS_EN
  ,
  output logic [15:0] nak_count
`endif
);

  localparam int RTY_W = $clog2(MAX_RETRY) + 1;
  localparam int TMO_W = $clog2(TIMEOUT) + 1;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;

  typedef enum logic [3:0] {
    IDLE, TOKEN, TOK_SEND, DATA, DAT_SEND, WAIT_HS, WAIT_DATA, ACK, ACK_SEND, FIN
  } state_t;

  state_t state_q, state_d;

  logic             is_in_q;
  logic [6:0]       addr_q;
  logic [3:0]       endp_q;
  logic [63:0]      wdata_q;
  logic [RTY_W-1:0] retry_q;
  logic [RTY_W-1:0] retry_inc;
  logic [TMO_W-1:0] tmo_q;
  logic             fail_att, pass, capture, tmo_hit, last_try, waiting;

  assign retry_inc = retry_q + 1'b1;
  assign last_try  = (retry_inc >= RTY_W'(MAX_RETRY));
  // Fires on the TIMEOUT-th cycle spent waiting, so each wait lasts exactly TIMEOUT cycles.
  assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT - 1));
  assign waiting   = (state_q == WAIT_HS) || (state_q == WAIT_DATA);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    fail_att = 1'b0;
    pass     = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE:      if (start) state_d = TOKEN;
      TOKEN:     if (gotpkt_bs) state_d = TOK_SEND;
      TOK_SEND:  if (!sending_bs) state_d = is_in_q ? WAIT_DATA : DATA;
      DATA:      if (gotpkt_bs) state_d = DAT_SEND;
      DAT_SEND:  if (!sending_bs) state_d = WAIT_HS;
      WAIT_HS: begin
        if (in_error || (in_ack && in_nak)) fail_att = 1'b1;
        else if (in_ack)                    pass     = 1'b1;
        else if (in_nak || tmo_hit)         fail_att = 1'b1;
      end
      WAIT_DATA: begin
        if (in_error) fail_att = 1'b1;
        else if (in_pktready) begin
          capture = 1'b1;
          state_d = ACK;
        end
        else if (in_nak || tmo_hit) fail_att = 1'b1;
      end
      ACK:       if (gotpkt_bs) state_d = ACK_SEND;
      ACK_SEND:  if (!sending_bs) pass = 1'b1;
      FIN:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (pass)     state_d = FIN;
    if (fail_att) state_d = last_try ? FIN : TOKEN;
  end

  always_comb begin
    pid         = 4'h0;
    addr        = 7'h0;
    endp        = 4'h0;
    data        = 64'h0;
    pkttype     = 1'b0;
    pktready_bs = 1'b0;
    writing     = 1'b0;
    busy        = (state_q != IDLE);
    done        = (state_q == FIN);
    case (state_q)
      TOKEN, TOK_SEND: begin
        pid         = is_in_q ? PID_IN : PID_OUT;
        addr        = addr_q;
        endp        = endp_q;
        writing     = 1'b1;
        pktready_bs = (state_q == TOKEN);
      end
      DATA, DAT_SEND: begin
        pid         = PID_DATA0;
        data        = wdata_q;
        pkttype     = 1'b1;
        writing     = 1'b1;
        pktready_bs = (state_q == DATA);
      end
      ACK, ACK_SEND: begin
        pid         = PID_ACK;
        writing     = 1'b1;
        pktready_bs = (state_q == ACK);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_in_q <= 1'b0;
      addr_q  <= 7'h0;
      endp_q  <= 4'h0;
      wdata_q <= 64'h0;
      retry_q <= '0;
      tmo_q   <= '0;
      success <= 1'b0;
      rd_data <= 64'h0;
    end else begin
      if (state_q == IDLE && start) begin
        is_in_q <= is_in;
        addr_q  <= txn_addr;
        endp_q  <= txn_endp;
        wdata_q <= wr_data;
        retry_q <= '0;
        success <= 1'b0;
      end
      if (fail_att) retry_q <= retry_inc;
      if (pass)     success <= 1'b1;
      if (capture)  rd_data <= in_data;
      if (!waiting)                        tmo_q <= '0;
      else if (tmo_q != TMO_W'(TIMEOUT))   tmo_q <= tmo_q + 1'b1;
    end
  end

`ifdef USB_TXN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                                           nak_count <= 16'h0;
    else if (waiting && in_nak && nak_count != 16'hFFFF) nak_count <= nak_count + 16'h1;
  end
`endif

endmodule
